serial_subtractor: RTL

Multi-cycle unsigned subtractor, the inverse operation to the 64-bit combinational ripple adder: it computes A − B and reports the borrow. It works one D-bit digit per clock through a single-digit borrow chain, so area scales with D rather than W. It sits beside the adder in the arithmetic datapath and is driven by a start/busy/done handshake. Its result format mirrors the adder's (W+1)-bit SUM, with the top bit carrying borrow instead of carry.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle unsigned subtractor computing A - B one
// D-bit digit per clock through a single-digit borrow chain. The result is
// presented on DIFF with the final borrow in the top bit, alongside a
// start/busy/done handshake.
module serial_subtractor #(
    parameter int W = 64,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W:0]   DIFF
);

    // Guarded digit width so the digit count never divides by zero while
    // the parameter check below reports the illegal configuration.
    localparam int DS = (D < 1) ? 1 : D;
    localparam int N  = W / DS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if (D < 1) begin : g_bad_digit
            $error("serial_subtractor: D must be at least 1");
        end else if ((W % D) != 0) begin : g_bad_width
            $error("serial_subtractor: W must be a multiple of D");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t        state;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W-1:0]  work;
    logic [W-1:0]  work_next;
    logic [IW-1:0] idx;
    logic          borrow;
    logic [D-1:0]  digit_a;
    logic [D-1:0]  digit_b;
    logic [D:0]    r;
    logic          last_digit;

    // One digit of A + ~B + ~borrow; the carry out of the digit is the
    // inverse of the borrow passed on to the next digit.
    always_comb begin
        digit_a    = opa[int'(idx)*D +: D];
        digit_b    = opb[int'(idx)*D +: D];
        r          = {1'b0, digit_a} + {1'b0, ~digit_b} + {{D{1'b0}}, ~borrow};
        work_next  = work;
        work_next[int'(idx)*D +: D] = r[D-1:0];
        last_digit = (idx == IW'(N - 1));
    end

    // Handshake FSM, operand latching, digit sequencing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            work   <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            DIFF   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa    <= A;
                        opb    <= B;
                        work   <= '0;
                        idx    <= '0;
                        borrow <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    work   <= work_next;
                    borrow <= ~r[D];
                    if (last_digit) begin
                        idx   <= '0;
                        DIFF  <= {~r[D], work_next};
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
